mp_add_sequencer: RTL

- Multi-precision add/subtract controller that sits directly upstream of the team's 8-bit ripple adder (`main`: a, b, cin -> z, cout).
- Accepts wide operand pairs over a valid/ready handshake and feeds the adder one byte per cycle, least-significant byte first, chaining carry between bytes.
- Assembles the wide result and presents it with carry-out and signed overflow over a second valid/ready handshake.
- The adder instance is external; this block drives its inputs and samples its outputs in the same cycle, since the adder path is purely combinational.

---
 rtl/mp_add_sequencer_if.sv | 35 +++
 rtl/mp_add_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/mp_add_sequencer_if.sv
// Handshake and adder-drive bundles for the multi-precision add/subtract sequencer.
// The operand stream, result stream and adder hookup are separate so each side can be wired independently.
interface mp_op_if #(parameter int NBYTES = 4);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   op_a;
    logic [8*NBYTES-1:0]   op_b;
    logic                  op_cin;
    logic                  op_sub;

    modport master (output in_valid, op_a, op_b, op_cin, op_sub, input in_ready);
    modport slave  (input in_valid, op_a, op_b, op_cin, op_sub, output in_ready);
endinterface

interface mp_res_if #(parameter int NBYTES = 4);
    logic                  res_valid;
    logic                  res_ready;
    logic [8*NBYTES-1:0]   result;
    logic                  res_cout;
    logic                  res_ovf;

    modport master (output res_valid, result, res_cout, res_ovf, input res_ready);
    modport slave  (input res_valid, result, res_cout, res_ovf, output res_ready);
endinterface

interface mp_adder_if;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_z;
    logic       add_cout;

    modport master (output add_a, add_b, add_cin, input add_z, add_cout);
    modport slave  (input add_a, add_b, add_cin, output add_z, add_cout);
endinterface

// File: rtl/mp_add_sequencer.sv
// Byte-serial multi-precision add/subtract controller driving an external 8-bit adder,
// least-significant byte first, carry chained through a register between bytes.
module mp_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    mp_op_if.slave     op,
    mp_res_if.master   res,
    mp_adder_if.master add
);
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [NBYTES-1:0][7:0] r_a;
    logic [NBYTES-1:0][7:0] r_b;
    logic [NBYTES-1:0][7:0] r_result;
    logic [IDXW-1:0]        r_idx;
    logic                   r_cin0;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   w_last;

    assign w_last        = (r_idx == LAST_IDX);
    assign res.result    = r_result;
    assign res.res_cout  = r_cout;
    assign res.res_ovf   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Adder inputs are driven only in RUN so the external adder sees zeros while idle.
    always_comb begin
        w_next        = r_state;
        op.in_ready   = 1'b0;
        res.res_valid = 1'b0;
        add.add_a     = 8'h00;
        add.add_b     = 8'h00;
        add.add_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                op.in_ready = 1'b1;
                if (op.in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                add.add_a   = r_a[r_idx];
                add.add_b   = r_b[r_idx];
                add.add_cin = (r_idx == '0) ? r_cin0 : r_carry;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                res.res_valid = 1'b1;
                if (res.res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is stored inverted and the first carry forced high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_cin0   <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op.in_valid) begin
                        r_a     <= op.op_a;
                        r_b     <= op.op_sub ? ~op.op_b : op.op_b;
                        r_cin0  <= op.op_sub | op.op_cin;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= add.add_z;
                    r_carry         <= add.add_cout;
                    r_idx           <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_cout <= add.add_cout;
                        r_ovf  <= (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) &&
                                  (add.add_z[7] != r_a[NBYTES-1][7]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
